// File: rtl/codedlock_guard.sv
// Supervisor for the codedlock comparator: turns match/mismatch edges into a timed
// door-open pulse, counts consecutive failures, and enforces a timed alarm lockout.
module codedlock_guard #(
  parameter int MAX_FAILS   = 3,
  parameter int OPEN_CYCLES = 1000,
  parameter int LOCK_CYCLES = 5000,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           match_in,
  input  logic                           mismatch_in,
  output logic                           unlock,
  output logic                           alarm,
  output logic                           locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int FW = $clog2(MAX_FAILS+1);
  localparam logic [FW-1:0]    FAIL_LAST = FW'(MAX_FAILS-1);
  localparam logic [FW-1:0]    FAIL_MAX  = FW'(MAX_FAILS);
  localparam logic [CNT_W-1:0] OPEN_LD   = CNT_W'(OPEN_CYCLES-1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_CYCLES-1);

  typedef enum logic [1:0] {IDLE, OPEN, LOCKOUT} state_t;

  // bit 0 carries match, bit 1 carries mismatch
  logic [1:0] s1, s2, p, rise;
  logic       ev_match, ev_mis;

  state_t           state, nstate;
  logic [CNT_W-1:0] timer, ntimer;
  logic [FW-1:0]    nfail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      p  <= '0;
    end else begin
      s1 <= {mismatch_in, match_in};
      s2 <= s1;
      p  <= s2;
    end
  end

  assign rise     = s2 & ~p;
  assign ev_mis   = rise[1];
  // a coincident mismatch wins over a match
  assign ev_match = rise[0] & ~rise[1];

  always_comb begin
    nstate = state;
    ntimer = timer;
    nfail  = fail_cnt;
    unique case (state)
      IDLE: begin
        if (ev_mis) begin
          if (fail_cnt >= FAIL_LAST) begin
            nfail  = FAIL_MAX;
            nstate = LOCKOUT;
            ntimer = LOCK_LD;
          end else begin
            nfail = fail_cnt + 1'b1;
          end
        end else if (ev_match) begin
          nstate = OPEN;
          ntimer = OPEN_LD;
          nfail  = '0;
        end
      end
      OPEN: begin
        if (ev_match)          ntimer = OPEN_LD;
        else if (timer == '0)  nstate = IDLE;
        else                   ntimer = timer - 1'b1;
      end
      LOCKOUT: begin
        // events are dropped here; the edge flops keep tracking so held levels die out
        if (timer == '0) begin
          nstate = IDLE;
          nfail  = '0;
        end else begin
          ntimer = timer - 1'b1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      fail_cnt   <= '0;
      unlock     <= 1'b0;
      alarm      <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= nstate;
      timer      <= ntimer;
      fail_cnt   <= nfail;
      unlock     <= (nstate == OPEN);
      alarm      <= (nstate == LOCKOUT);
      locked_out <= (nstate == LOCKOUT);
    end
  end

endmodule

// File: doc/codedlock_guard.md
# codedlock_guard

Downstream supervisor for the `codedlock` comparator. It consumes the comparator's match (`led1`) and mismatch (`led2`) indications and turns each new verdict into a timed door-open pulse or a counted failure. After `MAX_FAILS` consecutive failures it enforces a timed lockout with the alarm raised. It is the only block that drives the door actuator and alarm in the lock design.

## Interface
- `MAX_FAILS`, 3: consecutive mismatches that trigger lockout; must be ≥1.
- `OPEN_CYCLES`, 1000: clock cycles `unlock` stays high per accepted code; must be ≥1.
- `LOCK_CYCLES`, 5000: clock cycles of lockout; must be ≥1.
- `CNT_W`, 16: timer width; must satisfy 2^CNT_W > max(`OPEN_CYCLES`, `LOCK_CYCLES`).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `match_in`  in  1  `codedlock` `led1`; asynchronous level.
- `mismatch_in`  in  1  `codedlock` `led2`; asynchronous level.
- `unlock`  out  1  door actuator enable; registered.
- `alarm`  out  1  high for the whole lockout; registered.
- `locked_out`  out  1  state == LOCKOUT; registered.
- `fail_cnt`  out  $clog2(MAX_FAILS+1)  consecutive-failure count; registered.

## Operation
- **Input path:** each input goes through a 2-flop synchronizer (`s1`, `s2`) and then a previous-value flop (`p`).
- **Events:** an event is a rising edge on the synchronized signal (`s2 & ~p`). Levels held high produce exactly one event.
- **Simultaneous events:** a match event and a mismatch event in the same cycle count as a mismatch only.
- **FSM states:** IDLE, OPEN, LOCKOUT. A single down-counter `timer[CNT_W-1:0]` serves both timed states.
- **IDLE**
  - Match event: go to OPEN, load `timer` = `OPEN_CYCLES-1`, clear `fail_cnt`.
  - Mismatch event with `fail_cnt+1 < MAX_FAILS`: increment `fail_cnt`, stay in IDLE.
  - Mismatch event with `fail_cnt+1 == MAX_FAILS`: set `fail_cnt` = `MAX_FAILS`, go to LOCKOUT, load `timer` = `LOCK_CYCLES-1`.
- **OPEN**
  - `unlock` = 1.
  - Match event: reload `timer` = `OPEN_CYCLES-1` (retrigger).
  - Mismatch events are ignored and do not count.
  - `timer == 0` with no match event: go to IDLE. Otherwise decrement `timer`.
- **LOCKOUT**
  - `alarm` = 1 and `locked_out` = 1.
  - All events are discarded. The edge-detect flops still track their inputs, so a level held through lockout produces no event on exit.
  - `timer == 0`: go to IDLE and clear `fail_cnt`. Otherwise decrement `timer`.
- **`fail_cnt` bounds:** never exceeds `MAX_FAILS`. It only reaches `MAX_FAILS` while in LOCKOUT.
- **Output encoding:** outputs are registered and decoded from the next state, so no glitches.

## Timing
- **Reset:** all flops clear asynchronously. State = IDLE, `timer` = 0, `fail_cnt` = 0, `unlock` = `alarm` = `locked_out` = 0, synchronizer and edge flops = 0.
- **Reset mid-OPEN or mid-LOCKOUT:** immediate return to the reset values. Any lockout in progress is forgotten.
- **Latency:** if an input is first sampled high at edge k, the resulting state and output change is visible after edge k+2.
- **Open duration:** `unlock` is high for exactly `OPEN_CYCLES` cycles from the last match event.
- **Lockout duration:** `alarm` and `locked_out` are high for exactly `LOCK_CYCLES` cycles.
- **Timer-expiry boundary:** an event on the cycle the timer reaches 0 is handled as follows.
  - In OPEN, a match retriggers.
  - In LOCKOUT, the event is dropped. The FSM still exits to IDLE on that edge.
- **Minimum event spacing:** one event per input per 2 cycles. Input pulses shorter than 2 clock periods may be missed and are not required to register.

## Test plan
Parameters for all scenarios: `MAX_FAILS`=3, `OPEN_CYCLES`=8, `LOCK_CYCLES`=20.

1. **Reset values:** assert `rst` mid-cycle with no clock → all outputs 0 immediately. Release, hold inputs low 50 cycles → outputs stay 0.
2. **Single accepted code:** raise `match_in` and hold it high 100 cycles → `unlock` rises at edge k+2, stays high exactly 8 cycles, then 0. Only one pulse occurs; `fail_cnt` = 0.
3. **Failures reset by success:** two mismatch pulses (5 cycles each, 10-cycle gaps) → `fail_cnt` 1 then 2. A following match → `fail_cnt` 0 and an 8-cycle `unlock`.
4. **Lockout:** three mismatch pulses → on the third, `fail_cnt` = 3 and `alarm` = `locked_out` = 1 for exactly 20 cycles. A match pulse during lockout is ignored (`unlock` stays 0). On exit, `fail_cnt` = 0 and state is IDLE.
5. **Retrigger and simultaneity:**
   - A match at cycle 5 of OPEN → `unlock` is high 8 cycles counted from the second event.
   - A mismatch during OPEN → `fail_cnt` stays 0.
   - Match and mismatch rising together in IDLE → counted as a failure only, `fail_cnt` = 1, `unlock` = 0.
6. **Reset mid-lockout:** assert `rst` at lockout cycle 10 → `alarm` = 0 immediately. After release, a match pulse produces a normal 8-cycle `unlock`.
